flag_branch_unit: RTL

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

---
 rtl/flag_branch_unit_if.sv | 34 +++
 rtl/flag_branch_unit.sv | 91 +++++++++
 2 files changed

// File: rtl/flag_branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : flag_branch_unit_if
// Brief    : Control/status bundle between the datapath and flag_branch_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface flag_branch_unit_if;
  logic       Start;
  logic       Halt;
  logic       AluZero;
  logic       AluNegative;
  logic       FlagWrite;
  logic       BranchEn;
  logic [1:0] BranchCond;
  logic [7:0] BranchOffset;
  logic [9:0] PC;
  logic       ZeroFlag;
  logic       NegFlag;
  logic       Bubble;
  logic       Done;

  modport master (
    output Start, Halt, AluZero, AluNegative, FlagWrite,
           BranchEn, BranchCond, BranchOffset,
    input  PC, ZeroFlag, NegFlag, Bubble, Done
  );

  modport slave (
    input  Start, Halt, AluZero, AluNegative, FlagWrite,
           BranchEn, BranchCond, BranchOffset,
    output PC, ZeroFlag, NegFlag, Bubble, Done
  );
endinterface
`default_nettype wire

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_branch_unit
// Brief    : PC sequencer with stored Z/N flags, conditional branch and flush.
// Revision : 1.0 - initial release
// ============================================================================
module flag_branch_unit (
  input  wire                  Clk,
  input  wire                  Reset,
  flag_branch_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0] c_cond_always = 2'b00;
  localparam logic [1:0] c_cond_eq     = 2'b01;
  localparam logic [1:0] c_cond_ne     = 2'b10;

  state_t     r_state;
  logic [9:0] r_pc;
  logic       r_zero;
  logic       r_neg;
  logic       w_take;
  logic [9:0] w_offset;

  // Condition uses the stored flags so a same-cycle FlagWrite cannot affect it.
  always_comb begin
    w_take = 1'b0;
    case (bus.BranchCond)
      c_cond_always: w_take = 1'b1;
      c_cond_eq:     w_take = r_zero;
      c_cond_ne:     w_take = ~r_zero;
      default:       w_take = r_neg;
    endcase
  end

  assign w_offset = {{2{bus.BranchOffset[7]}}, bus.BranchOffset};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= 10'd0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pc <= 10'd0;
          if (bus.Start) r_state <= RUN;
        end
        RUN: begin
          if (bus.FlagWrite) begin
            r_zero <= bus.AluZero;
            r_neg  <= bus.AluNegative;
          end
          if (bus.Halt) begin
            r_state <= HALT;
          end else if (bus.BranchEn && w_take) begin
            r_pc    <= r_pc + w_offset;
            r_state <= FLUSH;
          end else begin
            r_pc <= r_pc + 10'd1;
          end
        end
        FLUSH: begin
          r_state <= RUN;
        end
        HALT: begin
          if (bus.Start) begin
            r_pc    <= 10'd0;
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.PC       = r_pc;
  assign bus.ZeroFlag = r_zero;
  assign bus.NegFlag  = r_neg;
  assign bus.Bubble   = (r_state == FLUSH);
  assign bus.Done     = (r_state == HALT);

endmodule
`default_nettype wire
